autoconfig_chain: RTL and testbench
===================================

AUTOCONFIG_CHAIN -- requirements
Module: autoconfig_chain

Interface
REQ-001 Parameter NUM_BOARDS, default 2, number of Zorro II autoconfig boards presented in sequence (1..4).
REQ-002 Parameter MFG_ID, default 16'h0000, 16-bit manufacturer number shared by all boards.
REQ-003 Parameter ER_TYPE, default {8'hC1, 8'hC2}, flattened 8 bits per board, board 0 in LSBs.
REQ-004 Parameter PRODUCT, default {8'h02, 8'h01}, flattened 8 bits per board, board 0 in LSBs.
REQ-005 Parameter ACK_LAT, default 2, CLK40 cycles from TSn sampled low to AC_TACK (1..7).
REQ-006 CLK40  in  1  sole clock; all state on rising edge.
REQ-007 RESETn  in  1  asynchronous active-low reset.
REQ-008 AUTOCONFIG_SPACE  in  1  decoded access to the autoconfig window.
REQ-009 TSn  in  1  transfer start, active low, one cycle.
REQ-010 RnW  in  1  1 = read, 0 = write.
REQ-011 CPUCONFn  in  1  config-in from chain; low = this block may respond.
REQ-012 AUTOBOOT  in  1  1 = ER_TYPE bit 4 (ROM vector valid) of board 0 reported set; 0 = forced clear.
REQ-013 A  in  7  address bits A[7:1], register offset.
REQ-014 D_IN  in  4  write nibble (D[7:4]).
REQ-015 D_OUT  out  4  read nibble.
REQ-016 AC_TACK  out  1  one-cycle acknowledge pulse, active high.
REQ-017 CONFIGENn  out  1  config-out to next device; low = all boards done.
REQ-018 CONFIGURED  out  NUM_BOARDS  per-board configured flag (shut-up boards stay 0).
REQ-019 BASE  out  4*NUM_BOARDS  per-board A[23:16] base high nibble pair stored as A[23:20]; board 0 in LSBs.

Function
REQ-020 Active board index CUR SHALL start at 0 and advance by 1 on each completing write; CUR == NUM_BOARDS means done.
REQ-021 Block SHALL respond only when AUTOCONFIG_SPACE=1, CPUCONFn=0 and CUR < NUM_BOARDS; otherwise D_OUT=0, no ack, no state change.
REQ-022 Reads: offsets $00/$02 SHALL return ER_TYPE[7:4]/[3:0] of CUR uninverted; $04/$06 PRODUCT nibbles, $10/$12/$14/$16 MFG_ID nibbles high-first, SHALL be inverted; every other offset returns 4'hF.
REQ-023 Read of $08 SHALL return ~4'h0 (flags zero); $4x offsets read 4'hF.
REQ-024 Write $4A SHALL latch D_IN into a staging nibble (no advance); write $48 SHALL load BASE[CUR] with D_IN, set CONFIGURED[CUR], advance CUR.
REQ-025 Write $4C (shut-up) SHALL advance CUR without setting CONFIGURED or BASE.
REQ-026 Writes to other offsets SHALL be acknowledged and ignored.
REQ-027 Register/advance action SHALL occur on the same edge AC_TACK is asserted; D_OUT SHALL be stable from TSn+1 through AC_TACK.
REQ-028 Ack FSM states IDLE -> WAIT (TSn low and respond condition) -> ACK (after ACK_LAT-1 WAIT cycles) -> IDLE; AC_TACK=1 only in ACK, exactly one cycle.
REQ-029 TSn low while not IDLE SHALL be ignored; a new transfer is accepted the cycle after ACK.
REQ-030 CONFIGENn SHALL go low the cycle after CUR reaches NUM_BOARDS and remain low until reset.
REQ-031 Deassertion of AUTOCONFIG_SPACE mid-transfer SHALL not abort the ack; write action still uses latched A/D_IN/RnW captured at TSn.

Reset
REQ-032 On RESETn low: FSM=IDLE, CUR=0, staging=0, CONFIGURED=0, BASE=0, AC_TACK=0, D_OUT=0, CONFIGENn=1, asynchronously, including mid-transfer.

Structure
REQ-033 Shared package autoconfig_pkg SHALL hold register offset constants ($00..$4C as A[7:1] codes), ack FSM state enum, and MAX_BOARDS=4.
REQ-034 Per-board nibble lookup and inversion SHALL be sub-module autoconfig_rom_lut (inputs CUR, offset, AUTOBOOT; output nibble).

Verification
REQ-035 Reset, read $00,$02 with AUTOBOOT=1 -> D_OUT 4'hC, 4'h1; AUTOBOOT=0 -> $02 reads 4'h1 with bit4 clear in byte (C1&~10 = C1 unchanged; use ER_TYPE=D1 -> $00 reads C).
REQ-036 Read $10..$16 with MFG_ID=16'h1234 -> 4'hE,4'hD,4'hC,4'hB; read $20 -> 4'hF.
REQ-037 Write $4A=4'h5 then $48=4'h2 -> BASE[3:0]=4'h2, CONFIGURED=2'b01, $04 now reads ~4'h0=F (board 1 product 8'h02 -> $06 reads 4'hD).
REQ-038 Board 0 shut-up ($4C) then board 1 $48=4'hA -> CONFIGURED=2'b10, BASE=8'hA0, CONFIGENn low next cycle, further accesses unacknowledged.
REQ-039 ACK_LAT=3: TSn low at cycle 0 -> AC_TACK high at cycle 3 only; second TSn at cycle 1 ignored.
REQ-040 RESETn pulsed low during WAIT after a $48 write -> no ack, CONFIGURED stays 0, CONFIGENn=1.

Source files
------------

// File: rtl/autoconfig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : autoconfig_pkg
//  Description : Shared constants and types for the Zorro II autoconfig chain:
//                register offsets (A[7:1] codes) and the ack FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package autoconfig_pkg;

   localparam int MAX_BOARDS = 4;
   // Board index must also encode the "all done" value MAX_BOARDS
   localparam int c_CUR_W    = 3;

   // Register offsets as A[7:1] codes (byte offset shifted right by one)
   localparam logic [6:0] c_OFS_ER_HI   = 7'h00;  // $00
   localparam logic [6:0] c_OFS_ER_LO   = 7'h01;  // $02
   localparam logic [6:0] c_OFS_PR_HI   = 7'h02;  // $04
   localparam logic [6:0] c_OFS_PR_LO   = 7'h03;  // $06
   localparam logic [6:0] c_OFS_FLAGS   = 7'h04;  // $08
   localparam logic [6:0] c_OFS_MFG_0   = 7'h08;  // $10
   localparam logic [6:0] c_OFS_MFG_1   = 7'h09;  // $12
   localparam logic [6:0] c_OFS_MFG_2   = 7'h0A;  // $14
   localparam logic [6:0] c_OFS_MFG_3   = 7'h0B;  // $16
   localparam logic [6:0] c_OFS_BASE_HI = 7'h24;  // $48
   localparam logic [6:0] c_OFS_BASE_LO = 7'h25;  // $4A
   localparam logic [6:0] c_OFS_SHUTUP  = 7'h26;  // $4C

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } ack_state_t;

endpackage
`default_nettype wire

// File: rtl/autoconfig_rom_lut.sv
`default_nettype none
// ============================================================================
//  Module      : autoconfig_rom_lut
//  Description : Read-nibble lookup for the active board. ER_TYPE nibbles are
//                returned as-is, all other ROM nibbles are returned inverted.
//  Revision    : 1.0  initial release
// ============================================================================
module autoconfig_rom_lut
   import autoconfig_pkg::*;
#(
   parameter int                      NUM_BOARDS = 2,
   parameter logic [15:0]             MFG_ID     = 16'h0000,
   parameter logic [8*NUM_BOARDS-1:0] ER_TYPE    = {8'hC1, 8'hC2},
   parameter logic [8*NUM_BOARDS-1:0] PRODUCT    = {8'h02, 8'h01}
) (
   input  logic [c_CUR_W-1:0] i_cur,
   input  logic [6:0]         i_offset,
   input  logic               i_autoboot,
   output logic [3:0]         o_nibble
);

   logic [7:0] w_er;
   logic [7:0] w_pr;

   // Select the active board's bytes, apply AUTOBOOT to board 0, then decode offset
   always_comb begin
      w_er     = 8'h00;
      w_pr     = 8'h00;
      o_nibble = 4'hF;
      for (int i = 0; i < NUM_BOARDS; i++) begin
         if (i_cur == c_CUR_W'(i)) begin
            w_er = ER_TYPE[8*i +: 8];
            w_pr = PRODUCT[8*i +: 8];
         end
      end
      // AUTOBOOT low hides the ROM-vector-valid bit of board 0
      if (i_cur == '0 && !i_autoboot) begin
         w_er[4] = 1'b0;
      end
      case (i_offset)
         c_OFS_ER_HI: o_nibble = w_er[7:4];
         c_OFS_ER_LO: o_nibble = w_er[3:0];
         c_OFS_PR_HI: o_nibble = ~w_pr[7:4];
         c_OFS_PR_LO: o_nibble = ~w_pr[3:0];
         c_OFS_FLAGS: o_nibble = ~4'h0;
         c_OFS_MFG_0: o_nibble = ~MFG_ID[15:12];
         c_OFS_MFG_1: o_nibble = ~MFG_ID[11:8];
         c_OFS_MFG_2: o_nibble = ~MFG_ID[7:4];
         c_OFS_MFG_3: o_nibble = ~MFG_ID[3:0];
         default:     o_nibble = 4'hF;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/autoconfig_chain.sv
`default_nettype none
// ============================================================================
//  Module      : autoconfig_chain
//  Description : Presents NUM_BOARDS Zorro II autoconfig boards in sequence,
//                acknowledging each access ACK_LAT cycles after TSn.
//  Revision    : 1.0  initial release
// ============================================================================
module autoconfig_chain
   import autoconfig_pkg::*;
#(
   parameter int                      NUM_BOARDS = 2,
   parameter logic [15:0]             MFG_ID     = 16'h0000,
   parameter logic [8*NUM_BOARDS-1:0] ER_TYPE    = {8'hC1, 8'hC2},
   parameter logic [8*NUM_BOARDS-1:0] PRODUCT    = {8'h02, 8'h01},
   parameter int                      ACK_LAT    = 2
) (
   input  logic                    CLK40,
   input  logic                    RESETn,
   input  logic                    AUTOCONFIG_SPACE,
   input  logic                    TSn,
   input  logic                    RnW,
   input  logic                    CPUCONFn,
   input  logic                    AUTOBOOT,
   input  logic [7:1]              A,
   input  logic [3:0]              D_IN,
   output logic [3:0]              D_OUT,
   output logic                    AC_TACK,
   output logic                    CONFIGENn,
   output logic [NUM_BOARDS-1:0]   CONFIGURED,
   output logic [4*NUM_BOARDS-1:0] BASE
);

   localparam logic [c_CUR_W-1:0] c_DONE      = c_CUR_W'(NUM_BOARDS);
   localparam logic [2:0]         c_WAIT_LAST = (ACK_LAT > 1) ? 3'(ACK_LAT - 2) : 3'd0;

   ack_state_t                r_state;
   ack_state_t                w_next_state;
   logic [2:0]                r_wait_cnt;
   logic [6:0]                r_addr;
   logic [3:0]                r_data;
   logic                      r_rnw;
   logic [c_CUR_W-1:0]        r_cur;
   logic [3:0]                r_staging;
   logic [NUM_BOARDS-1:0]     r_configured;
   logic [4*NUM_BOARDS-1:0]   r_base;
   logic [3:0]                r_dout;
   logic                      r_configen_n;
   logic                      w_respond;
   logic                      w_accept;
   logic                      w_enter_ack;
   logic [6:0]                w_op_addr;
   logic [3:0]                w_op_data;
   logic                      w_op_rnw;
   logic [3:0]                w_lut_nibble;
   logic                      w_unused_staging;

   assign w_respond = AUTOCONFIG_SPACE && !CPUCONFn && (r_cur < c_DONE);
   assign w_accept  = (r_state == ST_IDLE) && !TSn && w_respond;

   // With ACK_LAT==1 the action edge is the accept edge, so use live bus values there
   assign w_op_addr = (r_state == ST_IDLE) ? A    : r_addr;
   assign w_op_data = (r_state == ST_IDLE) ? D_IN : r_data;
   assign w_op_rnw  = (r_state == ST_IDLE) ? RnW  : r_rnw;

   assign w_enter_ack = (w_next_state == ST_ACK) && (r_state != ST_ACK);

   // The staging nibble carries A[19:16]; only A[23:20] is decoded by this block
   assign w_unused_staging = ^r_staging;

   autoconfig_rom_lut #(
      .NUM_BOARDS (NUM_BOARDS),
      .MFG_ID     (MFG_ID),
      .ER_TYPE    (ER_TYPE),
      .PRODUCT    (PRODUCT)
   ) u_rom_lut (
      .i_cur      (r_cur),
      .i_offset   (A),
      .i_autoboot (AUTOBOOT),
      .o_nibble   (w_lut_nibble)
   );

   // Ack FSM state register
   always_ff @(posedge CLK40 or negedge RESETn) begin
      if (!RESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Ack FSM next state and acknowledge output
   always_comb begin
      w_next_state = r_state;
      AC_TACK      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = (ACK_LAT == 1) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt == c_WAIT_LAST) begin
               w_next_state = ST_ACK;
            end
         end
         ST_ACK: begin
            AC_TACK      = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Count WAIT cycles; cleared whenever the FSM is elsewhere
   always_ff @(posedge CLK40 or negedge RESETn) begin
      if (!RESETn) begin
         r_wait_cnt <= 3'd0;
      end else if (r_state != ST_WAIT) begin
         r_wait_cnt <= 3'd0;
      end else begin
         r_wait_cnt <= r_wait_cnt + 3'd1;
      end
   end

   // Capture the transfer at TSn and hold the read nibble until the ack completes
   always_ff @(posedge CLK40 or negedge RESETn) begin
      if (!RESETn) begin
         r_addr <= 7'h00;
         r_data <= 4'h0;
         r_rnw  <= 1'b1;
         r_dout <= 4'h0;
      end else if (w_accept) begin
         r_addr <= A;
         r_data <= D_IN;
         r_rnw  <= RnW;
         r_dout <= RnW ? w_lut_nibble : 4'h0;
      end else if (r_state == ST_ACK) begin
         r_dout <= 4'h0;
      end
   end

   // Register writes and board advance on the edge that raises AC_TACK
   always_ff @(posedge CLK40 or negedge RESETn) begin
      if (!RESETn) begin
         r_cur        <= '0;
         r_staging    <= 4'h0;
         r_configured <= '0;
         r_base       <= '0;
         r_configen_n <= 1'b1;
      end else begin
         if (w_enter_ack && !w_op_rnw) begin
            case (w_op_addr)
               c_OFS_BASE_LO: r_staging <= w_op_data;
               c_OFS_BASE_HI: begin
                  for (int i = 0; i < NUM_BOARDS; i++) begin
                     if (r_cur == c_CUR_W'(i)) begin
                        r_base[4*i +: 4] <= w_op_data;
                        r_configured[i]  <= 1'b1;
                     end
                  end
                  r_cur <= r_cur + c_CUR_W'(1);
               end
               c_OFS_SHUTUP: r_cur <= r_cur + c_CUR_W'(1);
               default: ;
            endcase
         end
         if (r_cur == c_DONE) begin
            r_configen_n <= 1'b0;
         end
      end
   end

   assign D_OUT      = r_dout;
   assign CONFIGENn  = r_configen_n;
   assign CONFIGURED = r_configured;
   assign BASE       = r_base;

endmodule
`default_nettype wire

// File: tb/tb_autoconfig_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_autoconfig_chain
//  Description : Self-checking bench for autoconfig_chain: transaction-level
//                model compared every cycle plus directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_autoconfig_chain;

   localparam int          NB  = 2;
   localparam logic [15:0] MFG = 16'h1234;
   localparam logic [15:0] ERT = {8'hC1, 8'hD1};
   localparam logic [15:0] PRD = {8'h02, 8'h01};
   localparam int          LAT = 3;

   logic            clk40 = 1'b0;
   logic            resetn, space, tsn, rnw, cpuconfn, autoboot;
   logic [7:1]      a;
   logic [3:0]      d_in;
   logic [3:0]      d_out;
   logic            ac_tack, configen_n;
   logic [NB-1:0]   configured;
   logic [4*NB-1:0] base;

   int n_checks = 0;
   int n_fail   = 0;

   autoconfig_chain #(
      .NUM_BOARDS (NB),
      .MFG_ID     (MFG),
      .ER_TYPE    (ERT),
      .PRODUCT    (PRD),
      .ACK_LAT    (LAT)
   ) dut (
      .CLK40            (clk40),
      .RESETn           (resetn),
      .AUTOCONFIG_SPACE (space),
      .TSn              (tsn),
      .RnW              (rnw),
      .CPUCONFn         (cpuconfn),
      .AUTOBOOT         (autoboot),
      .A                (a),
      .D_IN             (d_in),
      .D_OUT            (d_out),
      .AC_TACK          (ac_tack),
      .CONFIGENn        (configen_n),
      .CONFIGURED       (configured),
      .BASE             (base)
   );

   always #5 clk40 = ~clk40;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model (transaction level) ----------------
   int          cyc = 0;
   bit          m_busy;
   int          m_ack_cyc;
   logic [3:0]  m_dout;
   bit          m_wr;
   logic [7:0]  m_ofs;
   logic [3:0]  m_data;
   int          m_cur;
   logic [NB-1:0] m_conf;
   logic [3:0]  m_base [NB];
   bit          m_cfgen;
   logic [4*NB-1:0] exp_base;
   bit          was_busy;

   // Nibble a board presents at a byte offset, from the register map rules
   function automatic logic [3:0] nib(input int b, input logic [7:0] ofs, input bit ab);
      logic [15:0] er_all, pr_all, mfg;
      logic [7:0]  er, pr;
      er_all = ERT; pr_all = PRD; mfg = MFG;
      er = er_all[8*b +: 8];
      pr = pr_all[8*b +: 8];
      if (b == 0 && !ab) er[4] = 1'b0;
      case (ofs)
         8'h00: return er[7:4];
         8'h02: return er[3:0];
         8'h04: return ~pr[7:4];
         8'h06: return ~pr[3:0];
         8'h10: return ~mfg[15:12];
         8'h12: return ~mfg[11:8];
         8'h14: return ~mfg[7:4];
         8'h16: return ~mfg[3:0];
         default: return 4'hF;
      endcase
   endfunction

   // Compare DUT against the model, then step the model for the coming edge
   always @(negedge clk40) begin
      if (!resetn) begin
         m_busy = 0; m_cur = 0; m_conf = '0; m_cfgen = 1;
         for (int i = 0; i < NB; i++) m_base[i] = 4'h0;
      end
      for (int i = 0; i < NB; i++) exp_base[4*i +: 4] = m_base[i];
      check("tack",       32'(ac_tack),    32'(m_busy && cyc == m_ack_cyc));
      check("dout",       32'(d_out),      32'(m_busy ? m_dout : 4'h0));
      check("configen_n", 32'(configen_n), 32'(m_cfgen));
      check("configured", 32'(configured), 32'(m_conf));
      check("base",       32'(base),       32'(exp_base));
      if (resetn) begin
         if (m_cur == NB) m_cfgen = 0;
         was_busy = m_busy;
         if (m_busy && cyc == m_ack_cyc) m_busy = 0;
         if (!was_busy && !tsn && space && !cpuconfn && m_cur < NB) begin
            m_busy    = 1;
            m_ack_cyc = cyc + LAT;
            m_wr      = !rnw;
            m_ofs     = {a, 1'b0};
            m_data    = d_in;
            m_dout    = rnw ? nib(m_cur, {a, 1'b0}, autoboot) : 4'h0;
         end
         if (m_busy && m_wr && cyc + 1 == m_ack_cyc) begin
            if (m_ofs == 8'h48) begin
               m_base[m_cur] = m_data;
               m_conf[m_cur] = 1'b1;
               m_cur++;
            end else if (m_ofs == 8'h4C) begin
               m_cur++;
            end
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   logic [3:0] got;
   int         lat, n_ack, first;

   // One transfer; lat = cycles from TSn to AC_TACK, -1 if no ack within budget
   task automatic access(input bit rd, input logic [7:0] ofs, input logic [3:0] data,
                         output logic [3:0] nib_o, output int lat_o);
      @(posedge clk40); #1;
      a = ofs[7:1]; rnw = rd; d_in = data; tsn = 1'b0;
      @(posedge clk40); #1;
      tsn = 1'b1;
      nib_o = 4'h0; lat_o = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk40);
         if (ac_tack) begin
            nib_o = d_out; lat_o = i;
            break;
         end
      end
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] ofs, input logic [3:0] exp);
      logic [3:0] g; int l;
      access(1'b1, ofs, 4'h0, g, l);
      check(nm, 32'(g), 32'(exp));
      check({nm, "_lat"}, l, LAT);
   endtask

   task automatic wr_chk(input string nm, input logic [7:0] ofs, input logic [3:0] data);
      logic [3:0] g; int l;
      access(1'b0, ofs, data, g, l);
      check({nm, "_lat"}, l, LAT);
   endtask

   task automatic noack_chk(input string nm, input bit rd, input logic [7:0] ofs);
      logic [3:0] g; int l;
      access(rd, ofs, 4'h3, g, l);
      check(nm, l, -1);
   endtask

   task automatic reset_pulse();
      @(posedge clk40); #1; resetn = 1'b0;
      @(posedge clk40); #1; resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b1; tsn = 1'b1; space = 1'b1; rnw = 1'b1; cpuconfn = 1'b0;
      autoboot = 1'b1; a = '0; d_in = 4'h0;
      #1 resetn = 1'b0;
      @(negedge clk40);
      check("rst_configen_n", 32'(configen_n), 32'h1);
      check("rst_configured", 32'(configured), 32'h0);
      check("rst_base",       32'(base),       32'h0);
      check("rst_tack",       32'(ac_tack),    32'h0);
      @(posedge clk40); #1; resetn = 1'b1;

      // Identification reads, board 0 = D1 / product 01, MFG 1234
      rd_chk("rd00_ab1", 8'h00, 4'hD);
      rd_chk("rd02_ab1", 8'h02, 4'h1);
      autoboot = 1'b0;
      rd_chk("rd00_ab0", 8'h00, 4'hC);
      rd_chk("rd02_ab0", 8'h02, 4'h1);
      autoboot = 1'b1;
      rd_chk("rd10", 8'h10, 4'hE);
      rd_chk("rd12", 8'h12, 4'hD);
      rd_chk("rd14", 8'h14, 4'hC);
      rd_chk("rd16", 8'h16, 4'hB);
      rd_chk("rd20", 8'h20, 4'hF);
      rd_chk("rd08", 8'h08, 4'hF);
      rd_chk("rd04", 8'h04, 4'hF);
      rd_chk("rd06", 8'h06, 4'hE);
      rd_chk("rd40", 8'h40, 4'hF);

      // No response when not selected by the chain or outside the window
      cpuconfn = 1'b1;
      noack_chk("noack_cpuconf", 1'b1, 8'h00);
      cpuconfn = 1'b0;
      space = 1'b0;
      noack_chk("noack_space", 1'b0, 8'h48);
      space = 1'b1;

      // TSn held low for two cycles: only one ack, ACK_LAT cycles after the first
      n_ack = 0; first = -1;
      @(posedge clk40); #1;
      a = 7'h01; rnw = 1'b1; tsn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk40);
         if (ac_tack) begin
            n_ack++;
            if (first < 0) first = i;
         end
         @(posedge clk40); #1;
         if (i == 1) tsn = 1'b1;
      end
      check("double_ts_acks", n_ack, 1);
      check("double_ts_lat",  first, 3);

      // Configure board 0 at base nibble 2
      wr_chk("wr4A", 8'h4A, 4'h5);
      check("staging_no_adv", 32'(configured), 32'h0);
      wr_chk("wr48", 8'h48, 4'h2);
      check("b0_configured", 32'(configured), 32'h1);
      check("b0_base",       32'(base),       32'h02);
      rd_chk("b1_rd04", 8'h04, 4'hF);
      rd_chk("b1_rd06", 8'h06, 4'hD);
      rd_chk("b1_rd00", 8'h00, 4'hC);
      wr_chk("wr20_ignored", 8'h20, 4'h7);
      check("wr20_configured", 32'(configured), 32'h1);
      reset_pulse();

      // Reset during WAIT of a $48 write aborts it
      n_ack = 0;
      @(posedge clk40); #1;
      a = 7'h24; rnw = 1'b0; d_in = 4'h3; tsn = 1'b0;
      @(posedge clk40); #1;
      tsn = 1'b1; resetn = 1'b0;
      @(posedge clk40); #1;
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk40);
         if (ac_tack) n_ack++;
      end
      check("rstwait_acks",       n_ack, 0);
      check("rstwait_configured", 32'(configured), 32'h0);
      check("rstwait_configen_n", 32'(configen_n), 32'h1);

      // Shut up board 0, then configure board 1 with the window dropped mid-transfer
      wr_chk("wr4C", 8'h4C, 4'h0);
      check("shutup_configured", 32'(configured), 32'h0);
      lat = -1;
      @(posedge clk40); #1;
      a = 7'h24; rnw = 1'b0; d_in = 4'hA; tsn = 1'b0;
      @(posedge clk40); #1;
      tsn = 1'b1; space = 1'b0; a = 7'h00; d_in = 4'h0; rnw = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk40);
         if (ac_tack) begin
            lat = i;
            break;
         end
      end
      check("b1_lat",        lat, LAT);
      check("b1_configured", 32'(configured), 32'h2);
      check("b1_base",       32'(base),       32'hA0);
      check("b1_cfgen_at_ack", 32'(configen_n), 32'h1);
      @(negedge clk40);
      check("b1_cfgen_after", 32'(configen_n), 32'h0);
      space = 1'b1;

      // Chain done: nothing answers
      noack_chk("done_rd", 1'b1, 8'h00);
      noack_chk("done_wr", 1'b0, 8'h48);
      check("done_configen_n", 32'(configen_n), 32'h0);
      repeat (3) @(posedge clk40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
